nn_regfile_v2: RTL and testbench
================================

Name: nn_regfile_v2

Overview:
Parametrised two-read, two-write register file for the neural network processor datapath, replacing the single-write, fixed-size file. It adds a synchronous clear sweep after reset or on request, an optional hardwired zero register, write-to-read bypass, and a per-entry pending scoreboard for multi-cycle MAC/activation results. It sits between decode (reads, reservations) and the two writeback paths (ALU port 0, MAC/activation port 1).

Parameters:
DATA_W, 32, word width
ADDR_W, 5, address width
DEPTH, 1<<ADDR_W, number of entries (must be <= 2^ADDR_W)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data and pending-clear forwarded to read ports

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clr_req  in  1  start clear sweep (honoured only when ready=1)
ready  out  1  1 = sweep done, file accepts writes and reservations
rd_addr1, rd_addr2  in  ADDR_W  read addresses
rd_data1, rd_data2  out  DATA_W  read data (combinational)
rd_busy1, rd_busy2  out  1  pending bit of the addressed entry
wr0_en, wr1_en  in  1  write enables
wr0_addr, wr1_addr  in  ADDR_W  write addresses
wr0_data, wr1_data  in  DATA_W  write data
rsv_en  in  1  mark entry pending
rsv_addr  in  ADDR_W  entry to reserve
wr_conflict  out  1  registered pulse: both ports wrote the same address

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset is sampled on the posedge with rst_n=0. At that edge: FSM goes to CLEAR, clr_ptr=0, all pending bits=0, ready=0, wr_conflict=0.
- FSM has two states, CLEAR and READY.
- In CLEAR, each posedge writes 0 to entry clr_ptr, then increments clr_ptr. The edge that writes entry DEPTH-1 moves the FSM to READY and sets ready=1. So ready rises DEPTH clocks after rst_n returns high.
- In CLEAR: wr*_en, rsv_en and clr_req are ignored; rd_data*=0 and rd_busy*=0.
- In READY, clr_req=1 at a posedge moves to CLEAR with clr_ptr=0 and all pending bits=0. Writes or reservations in that same cycle are dropped.
- Writes happen on posedge when ready=1 and the port's en=1.
  - wr0 and wr1 to the same address: wr1 wins, and wr_conflict=1 on the next cycle only.
  - With ZERO_REG=1, writes to address 0 are discarded and do not raise wr_conflict.
  - Addresses >= DEPTH are discarded.
- Reads are combinational from the array.
  - BYPASS=1: if a write port is enabled and ready=1 with a matching address, rd_data returns that write data in the same cycle (wr1 over wr0). rd_busy is then 0 unless rsv_en targets the same address.
  - BYPASS=0: rd_data shows the new value from the next cycle.
  - ZERO_REG=1 and address 0: rd_data=0, rd_busy=0.
  - Address >= DEPTH: rd_data=0, rd_busy=0.
- Scoreboard, evaluated at posedge when ready=1:
  - rsv_en sets pending[rsv_addr].
  - Any write clears pending[wr addr].
  - Reserve and write to the same address in one cycle: the set wins, so the entry stays pending with the new data stored.
- rst_n low mid-sweep restarts the sweep from entry 0.

Decomposition:
- Package nn_rf_pkg holds:
  - defaults DATA_W_DEF / ADDR_W_DEF;
  - state enum rf_state_t {RF_CLEAR, RF_READY};
  - function rf_addr_valid(addr, depth).
- Sub-module nn_rf_scoreboard holds the pending bit vector, its set/clear/flush logic and the busy lookup.
- Array, clear FSM and bypass muxing stay in the top.

Test Plan:
- Reset sweep: DEPTH=32, rst_n low 1 cycle then high -> ready=0 for 32 cycles, ready=1 on the 32nd edge, and every address reads 0x00000000.
- Dual write: wr0 (3, 0xAAAA0001) and wr1 (7, 0x5555_0002) in one cycle -> next cycle rd_addr1=3 gives 0xAAAA0001, rd_addr2=7 gives 0x55550002, wr_conflict=0.
- Conflict: wr0 (5, 0x11) and wr1 (5, 0x22) -> entry 5 = 0x22, wr_conflict=1 for exactly one cycle.
- Bypass: BYPASS=1, wr1 (9, 0xDEADBEEF) with rd_addr1=9 in the same cycle -> rd_data1=0xDEADBEEF combinationally. BYPASS=0 -> old value that cycle, new value the next.
- Scoreboard: rsv 12 -> rd_busy=1 next cycle; wr0 to 12 -> busy=0. Reserve and write 12 in the same cycle -> busy=1, data updated.
- Zero register and clr_req:
  - Write 0xFF to address 0 -> reads 0, no conflict.
  - clr_req in READY with entry 4=0x77 and pending -> ready=0 for 32 cycles, then entry 4=0, busy=0.

Source files
------------

// File: rtl/nn_rf_pkg.sv
// nn_rf_pkg: shared defaults, clear-sweep states and address range check for nn_regfile_v2
package nn_rf_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
   function automatic logic rf_addr_valid(input logic [31:0] addr, input int depth);
      return addr < 32'(depth);
   endfunction
endpackage

// File: rtl/nn_regfile_v2_if.sv
// nn_regfile_v2_if: read, write, reservation and status signals between pipeline and register file
interface nn_regfile_v2_if
   import nn_rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              clr_req, ready, wr_conflict;
   logic [ADDR_W-1:0] rd_addr1, rd_addr2;
   logic [DATA_W-1:0] rd_data1, rd_data2;
   logic              rd_busy1, rd_busy2;
   logic              wr0_en, wr1_en, rsv_en;
   logic [ADDR_W-1:0] wr0_addr, wr1_addr, rsv_addr;
   logic [DATA_W-1:0] wr0_data, wr1_data;
   modport master (
      output clr_req, rd_addr1, rd_addr2, wr0_en, wr0_addr, wr0_data,
             wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
      input  ready, rd_data1, rd_data2, rd_busy1, rd_busy2, wr_conflict
   );
   modport slave (
      input  clr_req, rd_addr1, rd_addr2, wr0_en, wr0_addr, wr0_data,
             wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
      output ready, rd_data1, rd_data2, rd_busy1, rd_busy2, wr_conflict
   );
endinterface

// File: rtl/nn_rf_scoreboard.sv
// nn_rf_scoreboard: per-entry pending bits for multi-cycle results, with flush and busy lookup
module nn_rf_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   set_en,
   input  logic [ADDR_W-1:0]      set_addr,
   input  logic                   clr0_en,
   input  logic [ADDR_W-1:0]      clr0_addr,
   input  logic                   clr1_en,
   input  logic [ADDR_W-1:0]      clr1_addr,
   input  logic [1:0][ADDR_W-1:0] look_addr,
   output logic [1:0]             busy
);
   logic [DEPTH-1:0] pending, pending_nxt;
   // writebacks clear their entry, then a reservation sets its entry so set wins on overlap
   always_comb begin
      pending_nxt = pending;
      if (clr0_en) pending_nxt[clr0_addr] = 1'b0;
      if (clr1_en) pending_nxt[clr1_addr] = 1'b0;
      if (set_en) pending_nxt[set_addr] = 1'b1;
   end
   // pending register, emptied by reset or a clear request
   always_ff @(posedge clk)
      pending <= (!rst_n || flush) ? '0 : pending_nxt;
   // a same-cycle writeback hides the stale pending bit unless the entry is re-reserved too
   always_comb
      for (int i = 0; i < 2; i++)
         busy[i] = (BYPASS && ((clr0_en && clr0_addr == look_addr[i]) || (clr1_en && clr1_addr == look_addr[i])))
                 ? (set_en && set_addr == look_addr[i]) : pending[look_addr[i]];
endmodule

// File: rtl/nn_regfile_v2.sv
// nn_regfile_v2: 2R/2W register file with clear sweep, zero register, write bypass and pending scoreboard
module nn_regfile_v2
   import nn_rf_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DEPTH    = 1 << ADDR_W,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   nn_regfile_v2_if.slave bus
);
   function automatic logic usable(input logic [ADDR_W-1:0] a);
      return rf_addr_valid(32'(a), DEPTH) && !(ZERO_REG && a == '0);
   endfunction
   rf_state_t                state, state_nxt;
   logic [ADDR_W-1:0]        clr_ptr, clr_ptr_nxt;
   logic [DATA_W-1:0]        mem [DEPTH];
   logic                     ready, sweep_last, wr_act, w0_ok, w1_ok, rsv_ok, conflict_q;
   logic [1:0][ADDR_W-1:0]   ra;
   logic [1:0][DATA_W-1:0]   rd;
   logic [1:0]               sb_busy;
   assign ready      = state == RF_READY;
   assign sweep_last = clr_ptr == ADDR_W'(DEPTH - 1);
   assign wr_act     = ready && !bus.clr_req;
   assign w0_ok      = wr_act && bus.wr0_en && usable(bus.wr0_addr);
   assign w1_ok      = wr_act && bus.wr1_en && usable(bus.wr1_addr);
   assign rsv_ok     = wr_act && bus.rsv_en && usable(bus.rsv_addr);
   assign ra         = {bus.rd_addr2, bus.rd_addr1};
   // sweep walks every entry then opens the file; a clear request restarts the sweep
   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      if (!ready) begin
         state_nxt   = sweep_last ? RF_READY : RF_CLEAR;
         clr_ptr_nxt = sweep_last ? '0 : clr_ptr + 1'b1;
      end else if (bus.clr_req) begin
         state_nxt   = RF_CLEAR;
         clr_ptr_nxt = '0;
      end
   end
   // state, sweep pointer and one-cycle conflict flag
   always_ff @(posedge clk) begin
      state      <= !rst_n ? RF_CLEAR : state_nxt;
      clr_ptr    <= !rst_n ? '0 : clr_ptr_nxt;
      conflict_q <= rst_n && w0_ok && w1_ok && bus.wr0_addr == bus.wr1_addr;
   end
   // sweep zeroes one entry per clock; port 1 commits last so it wins a shared address
   always_ff @(posedge clk)
      if (rst_n) begin
         if (!ready) mem[clr_ptr] <= '0;
         else begin
            if (w0_ok) mem[bus.wr0_addr] <= bus.wr0_data;
            if (w1_ok) mem[bus.wr1_addr] <= bus.wr1_data;
         end
      end
   // combinational read with optional forwarding of this cycle's write data, port 1 first
   always_comb
      for (int i = 0; i < 2; i++)
         rd[i] = (!ready || !usable(ra[i])) ? '0
               : (BYPASS && w1_ok && bus.wr1_addr == ra[i]) ? bus.wr1_data
               : (BYPASS && w0_ok && bus.wr0_addr == ra[i]) ? bus.wr0_data
               : mem[ra[i]];
   nn_rf_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(BYPASS)) u_sb (
      .clk(clk),
      .rst_n(rst_n),
      .flush(ready && bus.clr_req),
      .set_en(rsv_ok),
      .set_addr(bus.rsv_addr),
      .clr0_en(w0_ok),
      .clr0_addr(bus.wr0_addr),
      .clr1_en(w1_ok),
      .clr1_addr(bus.wr1_addr),
      .look_addr(ra),
      .busy(sb_busy)
   );
   assign bus.ready       = ready;
   assign bus.wr_conflict = conflict_q;
   assign bus.rd_data1    = rd[0];
   assign bus.rd_data2    = rd[1];
   assign bus.rd_busy1    = ready && usable(ra[0]) && sb_busy[0];
   assign bus.rd_busy2    = ready && usable(ra[1]) && sb_busy[1];
endmodule

// File: tb/tb_nn_regfile_v2.sv
// tb_nn_regfile_v2: two instances (32 entries with bypass, 24 entries without) against a behavioural model
module tb_nn_regfile_v2;
   localparam int DW = 32;
   localparam int AW = 5;
   logic clk = 0, rst_n = 0, run = 0;
   logic clr_req = 0, wr0_en = 0, wr1_en = 0, rsv_en = 0;
   logic [AW-1:0] rd_addr1 = 0, rd_addr2 = 0, wr0_addr = 0, wr1_addr = 0, rsv_addr = 0;
   logic [DW-1:0] wr0_data = 0, wr1_data = 0;
   logic [DW-1:0] rd1 [2], rd2 [2];
   logic b1 [2], b2 [2], rdy [2], conf [2];
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;

   nn_regfile_v2_if #(.DATA_W(DW), .ADDR_W(AW)) bus [2] ();
   for (genvar g = 0; g < 2; g++) begin : g_dut
      nn_regfile_v2 #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(g ? 24 : 32), .ZERO_REG(1'b1), .BYPASS(g == 0)) dut (
         .clk(clk), .rst_n(rst_n), .bus(bus[g]));
      assign bus[g].clr_req  = clr_req;
      assign bus[g].rd_addr1 = rd_addr1;
      assign bus[g].rd_addr2 = rd_addr2;
      assign bus[g].wr0_en   = wr0_en;
      assign bus[g].wr0_addr = wr0_addr;
      assign bus[g].wr0_data = wr0_data;
      assign bus[g].wr1_en   = wr1_en;
      assign bus[g].wr1_addr = wr1_addr;
      assign bus[g].wr1_data = wr1_data;
      assign bus[g].rsv_en   = rsv_en;
      assign bus[g].rsv_addr = rsv_addr;
      assign rd1[g]  = bus[g].rd_data1;
      assign rd2[g]  = bus[g].rd_data2;
      assign b1[g]   = bus[g].rd_busy1;
      assign b2[g]   = bus[g].rd_busy2;
      assign rdy[g]  = bus[g].ready;
      assign conf[g] = bus[g].wr_conflict;
   end

   // behavioural model: contents, pending flags, sweep progress per instance
   logic [DW-1:0] m_mem [2][32];
   logic m_pend [2][32];
   int m_cnt [2];
   logic m_rdy [2], m_conf [2];

   function automatic int dep(int g);
      return g ? 24 : 32;
   endfunction
   function automatic bit ok(int g, logic en, logic [AW-1:0] a);
      return en && a != 0 && int'(a) < dep(g);
   endfunction
   function automatic logic [DW-1:0] exp_rd(int g, logic [AW-1:0] a);
      if (!m_rdy[g] || !ok(g, 1'b1, a)) return '0;
      if (g == 0 && !clr_req && ok(g, wr1_en, wr1_addr) && wr1_addr == a) return wr1_data;
      if (g == 0 && !clr_req && ok(g, wr0_en, wr0_addr) && wr0_addr == a) return wr0_data;
      return m_mem[g][a];
   endfunction
   function automatic logic exp_busy(int g, logic [AW-1:0] a);
      if (!m_rdy[g] || !ok(g, 1'b1, a)) return 1'b0;
      if (g == 0 && !clr_req && ((ok(g, wr0_en, wr0_addr) && wr0_addr == a) || (ok(g, wr1_en, wr1_addr) && wr1_addr == a)))
         return ok(g, rsv_en, rsv_addr) && rsv_addr == a;
      return m_pend[g][a];
   endfunction

   always @(posedge clk)
      for (int g = 0; g < 2; g++) begin
         if (!rst_n) begin
            m_cnt[g] <= 0; m_rdy[g] <= 0; m_conf[g] <= 0;
            for (int i = 0; i < 32; i++) m_pend[g][i] <= 0;
         end else if (!m_rdy[g]) begin
            m_mem[g][m_cnt[g]] <= '0;
            m_cnt[g] <= m_cnt[g] + 1;
            m_rdy[g] <= m_cnt[g] == dep(g) - 1;
            m_conf[g] <= 0;
         end else if (clr_req) begin
            m_cnt[g] <= 0; m_rdy[g] <= 0; m_conf[g] <= 0;
            for (int i = 0; i < 32; i++) m_pend[g][i] <= 0;
         end else begin
            m_conf[g] <= ok(g, wr0_en, wr0_addr) && ok(g, wr1_en, wr1_addr) && wr0_addr == wr1_addr;
            if (ok(g, wr0_en, wr0_addr)) begin m_mem[g][wr0_addr] <= wr0_data; m_pend[g][wr0_addr] <= 0; end
            if (ok(g, wr1_en, wr1_addr)) begin m_mem[g][wr1_addr] <= wr1_data; m_pend[g][wr1_addr] <= 0; end
            if (ok(g, rsv_en, rsv_addr)) m_pend[g][rsv_addr] <= 1;
         end
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk)
      if (run)
         for (int g = 0; g < 2; g++) begin
            chk($sformatf("i%0d_ready", g), 32'(rdy[g]), 32'(m_rdy[g]));
            chk($sformatf("i%0d_conflict", g), 32'(conf[g]), 32'(m_conf[g]));
            chk($sformatf("i%0d_rd1", g), rd1[g], exp_rd(g, rd_addr1));
            chk($sformatf("i%0d_rd2", g), rd2[g], exp_rd(g, rd_addr2));
            chk($sformatf("i%0d_busy1", g), 32'(b1[g]), 32'(exp_busy(g, rd_addr1)));
            chk($sformatf("i%0d_busy2", g), 32'(b2[g]), 32'(exp_busy(g, rd_addr2)));
         end

   initial begin
      int n;
      @(posedge clk); #1;
      run = 1; rst_n = 1;
      chk("reset_ready", 32'(rdy[0]), 0);
      chk("reset_conflict", 32'(conf[0]), 0);
      n = 0;
      while (!rdy[0] && n < 100) begin cyc(); n++; end
      chk("sweep_len", 32'(n), 32);
      for (int a = 0; a < 32; a++) begin
         rd_addr1 = AW'(a); rd_addr2 = AW'(31 - a);
         @(negedge clk);
         chk("swept_rd1", rd1[0], 0);
         chk("swept_rd2", rd2[0], 0);
         cyc();
      end
      // dual write to distinct entries
      wr0_en = 1; wr0_addr = 3; wr0_data = 32'hAAAA0001;
      wr1_en = 1; wr1_addr = 7; wr1_data = 32'h55550002;
      cyc();
      wr0_en = 0; wr1_en = 0; rd_addr1 = 3; rd_addr2 = 7;
      @(negedge clk);
      chk("dual_rd1", rd1[0], 32'hAAAA0001);
      chk("dual_rd2", rd2[0], 32'h55550002);
      chk("dual_noconf", 32'(conf[0]), 0);
      // same-address conflict
      cyc();
      wr0_en = 1; wr0_addr = 5; wr0_data = 32'h11;
      wr1_en = 1; wr1_addr = 5; wr1_data = 32'h22;
      cyc();
      wr0_en = 0; wr1_en = 0; rd_addr1 = 5;
      @(negedge clk);
      chk("conf_data", rd1[0], 32'h22);
      chk("conf_pulse", 32'(conf[0]), 1);
      cyc();
      @(negedge clk);
      chk("conf_drop", 32'(conf[0]), 0);
      // bypass vs registered visibility
      cyc();
      wr1_en = 1; wr1_addr = 9; wr1_data = 32'hDEADBEEF; rd_addr1 = 9;
      @(negedge clk);
      chk("byp_on", rd1[0], 32'hDEADBEEF);
      chk("byp_off_old", rd1[1], 0);
      cyc();
      wr1_en = 0;
      @(negedge clk);
      chk("byp_off_new", rd1[1], 32'hDEADBEEF);
      // scoreboard
      cyc();
      rsv_en = 1; rsv_addr = 12;
      cyc();
      rsv_en = 0; rd_addr1 = 12;
      @(negedge clk);
      chk("rsv_busy0", 32'(b1[0]), 1);
      chk("rsv_busy1", 32'(b1[1]), 1);
      cyc();
      wr0_en = 1; wr0_addr = 12; wr0_data = 32'h1234;
      @(negedge clk);
      chk("wb_byp_busy0", 32'(b1[0]), 0);
      chk("wb_nobyp_busy1", 32'(b1[1]), 1);
      cyc();
      wr0_en = 0;
      @(negedge clk);
      chk("wb_busy0", 32'(b1[0]), 0);
      chk("wb_busy1", 32'(b1[1]), 0);
      chk("wb_data", rd1[1], 32'h1234);
      cyc();
      wr0_en = 1; wr0_addr = 12; wr0_data = 32'h5678; rsv_en = 1; rsv_addr = 12;
      @(negedge clk);
      chk("rsvwr_byp_busy", 32'(b1[0]), 1);
      cyc();
      wr0_en = 0; rsv_en = 0;
      @(negedge clk);
      chk("rsvwr_busy0", 32'(b1[0]), 1);
      chk("rsvwr_busy1", 32'(b1[1]), 1);
      chk("rsvwr_data", rd1[1], 32'h5678);
      // zero register
      cyc();
      wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFF;
      wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFF; rd_addr1 = 0;
      @(negedge clk);
      chk("zero_byp", rd1[0], 0);
      cyc();
      wr0_en = 0; wr1_en = 0;
      @(negedge clk);
      chk("zero_rd", rd1[0], 0);
      chk("zero_noconf", 32'(conf[0]), 0);
      // address beyond the 24-entry instance
      cyc();
      wr0_en = 1; wr0_addr = 25; wr0_data = 32'hCAFE;
      wr1_en = 1; wr1_addr = 25; wr1_data = 32'hBEEF;
      cyc();
      wr0_en = 0; wr1_en = 0; rd_addr2 = 25;
      @(negedge clk);
      chk("oor_big", rd2[0], 32'hBEEF);
      chk("oor_small", rd2[1], 0);
      chk("oor_conf_big", 32'(conf[0]), 1);
      chk("oor_conf_small", 32'(conf[1]), 0);
      // clear request wipes data and pending
      cyc();
      wr0_en = 1; wr0_addr = 4; wr0_data = 32'h77; rsv_en = 1; rsv_addr = 4;
      cyc();
      wr0_en = 0; rsv_en = 0; rd_addr1 = 4;
      @(negedge clk);
      chk("pre_clr_data", rd1[0], 32'h77);
      chk("pre_clr_busy", 32'(b1[0]), 1);
      cyc();
      clr_req = 1;
      cyc();
      clr_req = 0;
      chk("clr_ready_drop", 32'(rdy[0]), 0);
      n = 0;
      while (!rdy[0] && n < 100) begin cyc(); n++; end
      chk("clr_sweep_len", 32'(n), 32);
      @(negedge clk);
      chk("post_clr_data", rd1[0], 0);
      chk("post_clr_busy", 32'(b1[0]), 0);
      // reset in the middle of a sweep restarts it
      cyc();
      clr_req = 1;
      cyc();
      clr_req = 0;
      repeat (10) cyc();
      rst_n = 0;
      cyc();
      rst_n = 1;
      n = 0;
      while (!rdy[0] && n < 100) begin cyc(); n++; end
      chk("restart_len", 32'(n), 32);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
